// File: rtl/ov_frame_ctrl.sv
// OV camera frame capture controller: vsync-framed FIFO write control with reader handoff.
// Optional capture watchdog is built when OV_FRAME_TIMEOUT_EN is defined.
module ov_frame_ctrl #(
  parameter int unsigned WRST_CYCLES    = 4,
  parameter int unsigned VSYNC_POL      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       initialized,
  input  logic       vsync,
  input  logic       capture_en,
  input  logic       snap,
  input  logic       frame_read,
  output logic       wen,
  output logic       wrst,
  output logic       new_frame,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_WRST,
    S_CAPTURE,
    S_HANDOFF,
    S_READING
  } state_e;

  localparam logic       VS_ACT    = (VSYNC_POL != 0);
  localparam logic [3:0] WRST_LAST = 4'(WRST_CYCLES - 1);

  state_e     state_q, state_d;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic       vs_edge;
  logic [3:0] wcnt_q, wcnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wen_q, wrst_q, nf_q, busy_q, to_q;
  logic       to_hit, to_pulse;

  assign vs_edge = (vs_s2_q == VS_ACT) && (vs_s3_q != VS_ACT);

  // vs_s3_q only remembers the previous synchronized level for edge detection
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1_q <= ~VS_ACT;
      vs_s2_q <= ~VS_ACT;
      vs_s3_q <= ~VS_ACT;
    end else begin
      vs_s1_q <= vsync;
      vs_s2_q <= vs_s1_q;
      vs_s3_q <= vs_s2_q;
    end
  end

`ifdef OV_FRAME_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] tmo_q, tmo_d;

  assign to_hit = (tmo_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q == S_WAIT_VS || state_q == S_CAPTURE) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    cnt_d    = cnt_q;
    to_pulse = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (initialized && (capture_en || snap)) begin
          state_d = S_WAIT_VS;
        end
      end
      S_WAIT_VS: begin
        if (!initialized) begin
          state_d = S_IDLE;
        end else if (to_hit) begin
          state_d  = S_IDLE;
          to_pulse = 1'b1;
        end else if (vs_edge) begin
          state_d = S_WRST;
        end
      end
      S_WRST: begin
        if (!initialized) begin
          state_d = S_IDLE;
        end else if (wcnt_q == WRST_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_CAPTURE: begin
        if (!initialized) begin
          state_d = S_IDLE;
        end else if (to_hit) begin
          state_d  = S_IDLE;
          to_pulse = 1'b1;
        end else if (vs_edge) begin
          state_d = S_HANDOFF;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_HANDOFF: begin
        if (!frame_read) begin
          state_d = S_READING;
        end
      end
      S_READING: begin
        if (frame_read) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      wcnt_d = '0;
    end
  end

  // outputs are decoded from the next state so they line up with the transition edge
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      wrst_q  <= 1'b1;
      nf_q    <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      wen_q   <= (state_d == S_CAPTURE);
      wrst_q  <= (state_d != S_WRST);
      nf_q    <= (state_d == S_HANDOFF);
      busy_q  <= (state_d != S_IDLE);
      to_q    <= to_pulse;
    end
  end

  assign wen       = wen_q;
  assign wrst      = wrst_q;
  assign new_frame = nf_q;
  assign busy      = busy_q;
  assign frame_cnt = cnt_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_ov_frame_ctrl.sv
// Scoreboard bench for ov_frame_ctrl: frame timing predicted from vsync times.
// Watchdog checks are compiled in only with OV_FRAME_TIMEOUT_EN.
module tb_ov_frame_ctrl;

  localparam int WRST = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       initialized;
  logic       vsync;
  logic       capture_en;
  logic       snap;
  logic       frame_read;
  logic       wen;
  logic       wrst;
  logic       new_frame;
  logic       busy;
  logic [7:0] frame_cnt;
  logic       timeout;

  ov_frame_ctrl #(
    .WRST_CYCLES    (WRST),
    .VSYNC_POL      (1),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_25MHz   (clk),
    .rst_n       (rst_n),
    .initialized (initialized),
    .vsync       (vsync),
    .capture_en  (capture_en),
    .snap        (snap),
    .frame_read  (frame_read),
    .wen         (wen),
    .wrst        (wrst),
    .new_frame   (new_frame),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .timeout     (timeout)
  );

  always #20 clk = ~clk;

  typedef struct {
    int wrst_fall;
    int wen_rise;
    int wen_fall;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   model_cnt = 0;
  int   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: record observed edges, compare against the queue on each new frame
  initial begin
    int   m_wrst_fall, m_wen_rise, m_wen_fall;
    logic p_wrst, p_wen, p_nf;
    exp_t e;
    m_wrst_fall = -1;
    m_wen_rise  = -1;
    m_wen_fall  = -1;
    p_wrst = 1'b1;
    p_wen  = 1'b0;
    p_nf   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (p_wrst && !wrst) m_wrst_fall = cyc;
        if (!p_wen && wen) m_wen_rise = cyc;
        if (p_wen && !wen) m_wen_fall = cyc;
        if (!p_nf && new_frame) begin
          if (exp_q.size() == 0) begin
            check("nf_unexpected", int'(new_frame), 0);
          end else begin
            e = exp_q.pop_front();
            check("wrst_fall", m_wrst_fall, e.wrst_fall);
            check("wen_rise", m_wen_rise, e.wen_rise);
            check("wen_fall", m_wen_fall, e.wen_fall);
            check("frame_cnt", int'(frame_cnt), e.cnt);
          end
        end
      end
      p_wrst = wrst;
      p_wen  = wen;
      p_nf   = new_frame;
    end
  end

  task automatic pulse_snap();
    @(posedge clk); #1 snap = 1'b1;
    @(posedge clk); #1 snap = 1'b0;
  endtask

  task automatic vs_pulse();
    #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
  endtask

  task automatic wait_wen();
    int n = 0;
    while (!wen && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("wen_up", int'(wen), 1);
  endtask

  task automatic do_frame(input int gap, input int rd, input bit shot,
                          input bit early);
    int   t0, t1, n;
    exp_t e;
    if (shot) pulse_snap();
    repeat (3) @(posedge clk);
    #1 t0 = cyc;
    vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (gap) @(posedge clk);
    #1 t1 = cyc;
    vsync = 1'b1;
    model_cnt = (model_cnt + 1) % 256;
    e.wrst_fall = t0 + 3;
    e.wen_rise  = t0 + 3 + WRST;
    e.wen_fall  = t1 + 3;
    e.cnt       = model_cnt;
    exp_q.push_back(e);
    if (early) frame_read = 1'b0;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
    n = 0;
    while (!new_frame && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("nf_arrive", int'(new_frame), 1);
    if (!early) begin
      repeat (rd) @(posedge clk);
      #1 frame_read = 1'b0;
    end
    @(posedge clk); #1;
    check("nf_clear", int'(new_frame), 0);
    check("busy_rd", int'(busy), 1);
    vsync = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("wen_rd", int'(wen), 0);
    vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 frame_read = 1'b1;
    @(posedge clk); #1;
    check("busy_idle", int'(busy), 0);
    done++;
  endtask

  task automatic force_idle();
    capture_en = 1'b0;
    @(posedge clk); #1 initialized = 1'b0;
    @(posedge clk); #1;
    check("fidle_busy", int'(busy), 0);
    initialized = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wen"}, int'(wen), 0);
    check({tag, "_wrst"}, int'(wrst), 1);
    check({tag, "_nf"}, int'(new_frame), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_cnt"}, int'(frame_cnt), 0);
    check({tag, "_to"}, int'(timeout), 0);
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation bound exceeded, %0d expected frames pending",
             exp_q.size());
    $fatal(1, "bench watchdog");
  end

  initial begin
    rst_n = 1'b0;
    initialized = 1'b0;
    vsync = 1'b0;
    capture_en = 1'b0;
    snap = 1'b0;
    frame_read = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1 initialized = 1'b1;

    // single shot, vsync edges 1000 clocks apart, reader starts 2 clocks in
    do_frame(997, 2, 1'b1, 1'b0);
    check("shot_cnt", int'(frame_cnt), 1);

    capture_en = 1'b1;
    for (int i = 0; i < 3; i++)
      do_frame($urandom_range(40, 12), $urandom_range(4, 0), 1'b0, 1'b0);
    force_idle();
    check("cont_cnt", int'(frame_cnt), 4);

    do_frame(20, 0, 1'b1, 1'b1);

    // abort mid-capture
    pulse_snap();
    repeat (3) @(posedge clk);
    vs_pulse();
    wait_wen();
    repeat (5) @(posedge clk);
    #1 initialized = 1'b0;
    @(posedge clk); #1;
    check("abort_wen", int'(wen), 0);
    check("abort_wrst", int'(wrst), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_cnt", int'(frame_cnt), model_cnt);
    initialized = 1'b1;
    repeat (2) @(posedge clk);

    capture_en = 1'b1;
    while (done < 256)
      do_frame($urandom_range(30, 12), $urandom_range(3, 0), 1'b0,
               ($urandom_range(7, 0) == 0));
    force_idle();
    check("wrap_cnt", int'(frame_cnt), 0);

    // reset lands between clock edges during capture
    pulse_snap();
    repeat (3) @(posedge clk);
    vs_pulse();
    wait_wen();
    #5 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    model_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    do_frame(25, 1, 1'b1, 1'b0);
    check("post_rst_cnt", int'(frame_cnt), 1);

`ifdef OV_FRAME_TIMEOUT_EN
    begin
      int t, n;
      @(posedge clk); #1 snap = 1'b1;
      t = cyc;
      @(posedge clk); #1 snap = 1'b0;
      n = 0;
      while (!timeout && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      check("to_cycle", cyc - t, 101);
      check("to_busy", int'(busy), 0);
      check("to_wen", int'(wen), 0);
      @(posedge clk); #1;
      check("to_single", int'(timeout), 0);
    end
`endif

    repeat (5) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
